// File: rtl/de1soc_input_conditioner_pkg.sv
// Shared constants and the debouncer state type for the DE1-SoC input conditioner.
package de1soc_pkg;

    localparam int unsigned DEFAULT_SW_W            = 10;
    localparam int unsigned DEFAULT_KEY_W           = 4;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 50000;

    typedef enum logic {
        STABLE   = 1'b0,
        CHANGING = 1'b1
    } db_state_t;

endpackage

// File: rtl/de1soc_input_conditioner_if.sv
// Bundle of the raw board inputs and conditioned outputs of the input conditioner.
interface de1soc_input_conditioner_if #(
    parameter int unsigned SW_W  = 10,
    parameter int unsigned KEY_W = 4
);

    logic [SW_W-1:0]  SW;
    logic [KEY_W-1:0] KEY_N;
    logic [SW_W-1:0]  sw_o;
    logic [KEY_W-1:0] key_o;
    logic [KEY_W-1:0] key_press_o;
    logic [KEY_W-1:0] key_release_o;
    logic             sw_change_o;

    modport master (
        output SW, KEY_N,
        input  sw_o, key_o, key_press_o, key_release_o, sw_change_o
    );

    modport slave (
        input  SW, KEY_N,
        output sw_o, key_o, key_press_o, key_release_o, sw_change_o
    );

endinterface

// File: rtl/de1soc_input_conditioner_debounce_bit.sv
// One input bit: two-flop synchronizer, optional inversion, and a counting debouncer.
module debounce_bit
    import de1soc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic        RESET_LEVEL     = 1'b0,
    parameter logic        INVERT          = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic level_next
);

    localparam int unsigned       CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync_a;
    logic             sync_b;
    logic             sampled;
    db_state_t        state;
    db_state_t        state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] cnt_inc;

    // Reset parks the synchronizer at the idle (released) level of the pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= RESET_LEVEL;
            sync_b <= RESET_LEVEL;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    assign sampled = sync_b ^ INVERT;
    assign cnt_inc = cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= STABLE;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            level <= level_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        level_next = level;
        case (state)
            STABLE: begin
                if (sampled != level) begin
                    state_next = CHANGING;
                    cnt_next   = CNT_W'(1);
                end else begin
                    cnt_next = '0;
                end
            end
            CHANGING: begin
                if (sampled == level) begin
                    state_next = STABLE;
                    cnt_next   = '0;
                end else if (cnt_inc == CNT_LIMIT) begin
                    // Accept on the update that would reach the limit, so the count never wraps.
                    state_next = STABLE;
                    cnt_next   = '0;
                    level_next = ~level;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            default: begin
                state_next = STABLE;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: rtl/de1soc_input_conditioner.sv
// Debounces DE1-SoC slide switches and pushbuttons and derives registered change pulses.
module de1soc_input_conditioner
    import de1soc_pkg::*;
#(
    parameter int unsigned SW_W            = DEFAULT_SW_W,
    parameter int unsigned KEY_W           = DEFAULT_KEY_W,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SW_W-1:0]  SW,
    input  logic [KEY_W-1:0] KEY_N,
    output logic [SW_W-1:0]  sw_o,
    output logic [KEY_W-1:0] key_o,
    output logic [KEY_W-1:0] key_press_o,
    output logic [KEY_W-1:0] key_release_o,
    output logic             sw_change_o
);

    logic [SW_W-1:0]  sw_level;
    logic [SW_W-1:0]  sw_next;
    logic [KEY_W-1:0] key_level;
    logic [KEY_W-1:0] key_next;

    for (genvar i = 0; i < SW_W; i++) begin : g_sw
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_LEVEL     (1'b0),
            .INVERT          (1'b0)
        ) u_db (
            .clk        (clk),
            .rst_n      (rst_n),
            .raw        (SW[i]),
            .level      (sw_level[i]),
            .level_next (sw_next[i])
        );
    end

    for (genvar i = 0; i < KEY_W; i++) begin : g_key
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_LEVEL     (1'b1),
            .INVERT          (1'b1)
        ) u_db (
            .clk        (clk),
            .rst_n      (rst_n),
            .raw        (KEY_N[i]),
            .level      (key_level[i]),
            .level_next (key_next[i])
        );
    end

    assign sw_o  = sw_level;
    assign key_o = key_level;

    // Edges are taken from each debouncer's next value so pulses land with the level change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_press_o   <= '0;
            key_release_o <= '0;
            sw_change_o   <= 1'b0;
        end else begin
            key_press_o   <= key_next & ~key_level;
            key_release_o <= ~key_next & key_level;
            sw_change_o   <= |(sw_next ^ sw_level);
        end
    end

endmodule
